// File: rtl/ahb_lite_monitor_if.sv
// AHB-Lite bus signal bundle observed by ahb_lite_monitor.
// master/slave modports describe the real bus agents; monitor is fully passive.
interface ahb_lite_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

  modport monitor (
    input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_monitor.sv
// Passive AHB-Lite monitor: pairs address and data phases into transfer
// records, buffers them in a show-ahead FIFO and flags protocol errors.
module ahb_lite_monitor #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_lite_monitor_if.monitor bus,
  input  logic                clr,
  input  logic                rec_ready,
  output logic                rec_valid,
  output logic [ADDR_W-1:0]   rec_addr,
  output logic [DATA_W-1:0]   rec_data,
  output logic                rec_write,
  output logic [2:0]          rec_size,
  output logic                rec_resp,
  output logic                overflow,
  output logic [15:0]         drop_cnt,
  output logic [2:0]          err_flags
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_W / 8));

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              write;
    logic [2:0]        size;
    logic              resp;
  } rec_t;

  // True when any address bit below 2^size is set.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if ((i < ADDR_W) && (3'(i) < size)) begin
        bad = bad | addr[i];
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic              pend_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              pend_write_r;
  logic [2:0]        pend_size_r;
  logic              last_idle_r;
  rec_t              mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic              overflow_r;
  logic [15:0]       drop_cnt_r;
  logic [2:0]        err_r;

  logic       accept_s;
  logic       complete_s;
  logic       idle_s;
  logic       full_s;
  logic       pop_s;
  logic       push_ok_s;
  logic       drop_s;
  logic [2:0] new_err_s;
  rec_t       push_rec_s;

  assign accept_s   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign complete_s = pend_r & bus.HREADY;
  assign idle_s     = bus.HSEL & bus.HREADY & (bus.HTRANS == 2'b00);
  assign full_s     = (cnt_r == CW'(DEPTH));
  assign pop_s      = (cnt_r != CW'(0)) & rec_ready;
  assign push_ok_s  = complete_s & (~full_s | pop_s);
  assign drop_s     = complete_s & full_s & ~pop_s;

  // Build the completing record and the protocol errors of this edge.
  always_comb begin
    push_rec_s.addr  = pend_addr_r;
    push_rec_s.data  = pend_write_r ? bus.HWDATA : bus.HRDATA;
    push_rec_s.write = pend_write_r;
    push_rec_s.size  = pend_size_r;
    push_rec_s.resp  = bus.HRESP;
    new_err_s        = 3'b000;
    if (accept_s) begin
      new_err_s[0] = (bus.HTRANS == 2'b11) & last_idle_r;
      new_err_s[1] = (bus.HSIZE > SIZE_MAX);
      new_err_s[2] = misaligned(bus.HADDR, bus.HSIZE);
    end else begin
      new_err_s = 3'b000;
    end
  end

  // Single pending address-phase slot and IDLE history for the SEQ check.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_r       <= 1'b0;
      pend_addr_r  <= '0;
      pend_write_r <= 1'b0;
      pend_size_r  <= 3'b000;
      last_idle_r  <= 1'b1;
    end else begin
      if (accept_s) begin
        pend_r       <= 1'b1;
        pend_addr_r  <= bus.HADDR;
        pend_write_r <= bus.HWRITE;
        pend_size_r  <= bus.HSIZE;
        last_idle_r  <= 1'b0;
      end else if (complete_s) begin
        pend_r <= 1'b0;
      end
      if (idle_s) begin
        last_idle_r <= 1'b1;
      end
    end
  end

  // Record FIFO; a push into a full FIFO succeeds when the head pops on the same edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_rec_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky status; a new event on a clr edge takes precedence over the clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
      err_r      <= 3'b000;
    end else begin
      err_r      <= (clr ? 3'b000 : err_r) | new_err_s;
      overflow_r <= (clr ? 1'b0 : overflow_r) | drop_s;
      if (clr) begin
        drop_cnt_r <= drop_s ? 16'h0001 : 16'h0000;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
    end
  end

  assign rec_valid = (cnt_r != CW'(0));
  assign rec_addr  = mem_r[rd_ptr_r].addr;
  assign rec_data  = mem_r[rd_ptr_r].data;
  assign rec_write = mem_r[rd_ptr_r].write;
  assign rec_size  = mem_r[rd_ptr_r].size;
  assign rec_resp  = mem_r[rd_ptr_r].resp;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;
  assign err_flags = err_r;
endmodule
